// File: rtl/uart_core.sv
// rtl/uart_core.sv - 8N1 UART transceiver with a single-entry receive buffer
//
// Purpose: serialises one byte per tx_wr_i strobe onto uart_tx_o and
// deserialises uart_rx_i into a one-byte buffer that is popped by rx_rd_i.
// Bit time is BAUD_DIV system clocks (legal range 4..65535).
//
// Ports:
//   clk_i           system clock
//   rst_i           asynchronous active-high reset
//   tx_data_i       byte to transmit, latched on tx_wr_i
//   tx_wr_i         one-cycle write strobe, ignored while tx_busy_o=1
//   tx_busy_o       transmitter busy
//   rx_rd_i         one-cycle pop strobe for the receive buffer
//   rx_data_o       receive buffer contents (registered)
//   rx_not_empty_o  receive buffer holds an unread byte
//   uart_tx_o       serial output, idles high
//   uart_rx_i       serial input, asynchronous to clk_i
module uart_core #(
  parameter int unsigned BAUD_DIV = 217
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_wr_i,
  output logic       tx_busy_o,
  input  logic       rx_rd_i,
  output logic [7:0] rx_data_o,
  output logic       rx_not_empty_o,
  output logic       uart_tx_o,
  input  logic       uart_rx_i
);

  localparam int unsigned CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_e;

  // ---------------------------------------------------------------- transmitter
  tx_state_e     tx_state_q;
  logic [CW-1:0] tx_cnt_q;
  logic [2:0]    tx_bit_q;
  logic [7:0]    tx_shift_q;
  logic          tx_line_q;
  logic          tx_busy_q;

  // The line value for the next bit is registered at the bit boundary, so
  // uart_tx_o changes exactly BAUD_DIV clocks apart with no combinational path.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (tx_wr_i) begin
            tx_shift_q <= tx_data_i;
            tx_cnt_q   <= '0;
            tx_line_q  <= 1'b0;
            tx_busy_q  <= 1'b1;
            tx_state_q <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt_q == BAUD_LAST) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_line_q  <= tx_shift_q[0];
            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            tx_state_q <= TX_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
          end
        end
        TX_DATA: begin
          if (tx_cnt_q == BAUD_LAST) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'd7) begin
              tx_line_q  <= 1'b1;
              tx_state_q <= TX_STOP;
            end else begin
              tx_bit_q   <= tx_bit_q + 3'd1;
              tx_line_q  <= tx_shift_q[0];
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
          end
        end
        TX_STOP: begin
          if (tx_cnt_q == BAUD_LAST) begin
            tx_cnt_q   <= '0;
            tx_busy_q  <= 1'b0;
            tx_state_q <= TX_IDLE;
          end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  assign uart_tx_o = tx_line_q;
  assign tx_busy_o = tx_busy_q;

  // ------------------------------------------------------------------- receiver
  // Synchroniser flops reset to the idle level so reset release is not
  // mistaken for a start bit.
  logic rx_meta_q;
  logic rx_s_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  rx_state_e     rx_state_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_shift_q;

  // Start bit is checked at its midpoint; every later sample is one full bit
  // time on, which keeps all samples near bit centres.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      case (rx_state_q)
        RX_IDLE: begin
          if (!rx_s_q) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_s_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == BAUD_LAST) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_s_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) begin
              rx_state_q <= RX_STOP;
            end else begin
              rx_bit_q <= rx_bit_q + 3'd1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == BAUD_LAST) begin
            rx_cnt_q   <= '0;
            rx_state_q <= rx_s_q ? RX_IDLE : RX_BREAK;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        RX_BREAK: begin
          if (rx_s_q) begin
            rx_state_q <= RX_IDLE;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------ receive buffer
  // A load takes priority over a pop in the same cycle, and overwrites any
  // unread byte.
  logic       rx_load;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_ne_q, rx_ne_d;

  assign rx_load = (rx_state_q == RX_STOP) && (rx_cnt_q == BAUD_LAST) && rx_s_q;

  always_comb begin
    rx_data_d = rx_data_q;
    rx_ne_d   = rx_ne_q;
    if (rx_load) begin
      rx_data_d = rx_shift_q;
      rx_ne_d   = 1'b1;
    end else if (rx_rd_i) begin
      rx_ne_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_data_q <= '0;
      rx_ne_q   <= 1'b0;
    end else begin
      rx_data_q <= rx_data_d;
      rx_ne_q   <= rx_ne_d;
    end
  end

  assign rx_data_o      = rx_data_q;
  assign rx_not_empty_o = rx_ne_q;

endmodule

// File: tb/tb_uart_core.sv
// tb/tb_uart_core.sv - scoreboard testbench for uart_core
module tb_uart_core;

  localparam int B = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_wr = 1'b0;
  logic       rd_main = 1'b0;
  logic       rd_mon = 1'b0;
  logic       rx_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic       tx_busy, uart_tx, rx_ne;
  logic [7:0] rx_data;
  logic       uart_rx;

  assign uart_rx = loop_en ? uart_tx : rx_drv;

  always #5 clk = ~clk;

  uart_core #(.BAUD_DIV(B)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .tx_data_i     (tx_data),
    .tx_wr_i       (tx_wr),
    .tx_busy_o     (tx_busy),
    .rx_rd_i       (rd_main | rd_mon),
    .rx_data_o     (rx_data),
    .rx_not_empty_o(rx_ne),
    .uart_tx_o     (uart_tx),
    .uart_rx_i     (uart_rx)
  );

  int total = 0;
  int bad = 0;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  logic [7:0] last_rx = 8'h00;
  bit tx_mon_en = 1'b1;
  bit auto_pop = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference receive buffer: one entry, a new byte replaces an unread one.
  function automatic void rx_model_frame(input logic [7:0] b);
    if (rx_exp.size() != 0) rx_exp[rx_exp.size()-1] = b;
    else rx_exp.push_back(b);
    last_rx = b;
  endfunction

  // Expected line level i clocks into a frame: start 0, data LSB first, stop 1.
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    int k;
    k = i / B;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  // All stimulus tasks start and end just after a rising edge.
  task automatic tx_write(input logic [7:0] b, input bit accept);
    tx_data = b;
    tx_wr = 1'b1;
    if (accept) tx_exp.push_back(b);
    @(posedge clk); #1;
    tx_wr = 1'b0;
  endtask

  task automatic tx_write_exact(input logic [7:0] b);
    int busy_low;
    busy_low = 0;
    tx_write(b, 1'b1);
    for (int i = 0; i < 10 * B; i++) begin
      @(negedge clk);
      if (tx_busy !== 1'b1) busy_low++;
      if (i % B == 0 || i % B == B - 1)
        check($sformatf("tx_line_%0h_c%0d", b, i), uart_tx, frame_bit(b, i));
    end
    check("tx_busy_cycles_low", busy_low, 0);
    @(negedge clk);
    check("tx_busy_drop", tx_busy, 0);
    check("tx_line_idle", uart_tx, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_tx_idle();
    int n;
    n = 0;
    while (tx_busy === 1'b1 && n < 20 * B) begin
      @(posedge clk); #1;
      n++;
    end
    check("tx_idle_timeout", (n < 20 * B), 1);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = f[i];
      repeat (B) @(posedge clk);
      #1;
    end
  endtask

  // TX monitor: decodes frames off the line at bit centres.
  initial begin
    logic prev;
    logic s0, sp;
    logic [7:0] b, e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_mon_en && prev === 1'b1 && uart_tx === 1'b0) begin
        repeat (B / 2) @(negedge clk);
        s0 = uart_tx;
        for (int k = 0; k < 8; k++) begin
          repeat (B) @(negedge clk);
          b[k] = uart_tx;
        end
        repeat (B) @(negedge clk);
        sp = uart_tx;
        if (tx_exp.size() == 0) begin
          total++;
          bad++;
          $display("FAIL tx_unexpected_frame: got %0h expected none", b);
        end else begin
          e = tx_exp.pop_front();
          check("tx_frame", {sp, b, s0}, {1'b1, e, 1'b0});
        end
      end
      prev = uart_tx;
    end
  end

  // RX monitor: pops the buffer whenever it shows a byte.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (auto_pop && rx_ne === 1'b1) begin
        if (rx_exp.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rx_unexpected_byte: got %0h expected none", rx_data);
          e = rx_data;
        end else begin
          e = rx_exp.pop_front();
          check("rx_data", rx_data, e);
        end
        rd_mon = 1'b1;
        @(posedge clk); #1;
        rd_mon = 1'b0;
        @(negedge clk);
        check("rx_pop_clears", rx_ne, 0);
        check("rx_data_holds", rx_data, e);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int cnt, gap;

    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_busy", tx_busy, 0);
    check("rst_uart_tx", uart_tx, 1);
    check("rst_rx_ne", rx_ne, 0);
    check("rst_rx_data", rx_data, 8'h00);
    rst = 1'b0;
    @(posedge clk); #1;

    // Exact TX waveform
    tx_write_exact(8'hA5);
    repeat (5) @(posedge clk); #1;

    // Write while busy is dropped
    tx_write(8'h55, 1'b1);
    repeat (9) @(posedge clk); #1;
    tx_write(8'hFF, 1'b0);
    wait_tx_idle();
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || tx_busy !== 1'b0) cnt++;
    end
    check("idle_after_busy_write", cnt, 0);
    @(posedge clk); #1;

    // Random TX, including writes in the cycle busy drops
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      tx_write(b, 1'b1);
      wait_tx_idle();
      gap = (i % 3 == 0) ? 0 : $urandom_range(1, 5);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    repeat (10) @(posedge clk); #1;

    // Loopback
    loop_en = 1'b1;
    rx_model_frame(8'h3C);
    tx_write(8'h3C, 1'b1);
    wait_tx_idle();
    repeat (20) @(posedge clk); #1;
    loop_en = 1'b0;
    repeat (5) @(posedge clk); #1;

    // RX latency from start-bit edge to buffer visible
    b = 8'($urandom);
    rx_model_frame(b);
    cnt = 0;
    fork
      send_rx(b, 1'b1);
      begin
        while (cnt < 200) begin
          @(posedge clk);
          cnt++;
          @(negedge clk);
          if (rx_ne === 1'b1) break;
        end
      end
    join
    check("rx_latency", cnt, 2 + B / 2 + 9 * B + 1);
    repeat (3) @(posedge clk); #1;

    // Random RX
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      rx_model_frame(b);
      send_rx(b, 1'b1);
      repeat ($urandom_range(2, 10)) @(posedge clk);
      #1;
    end
    repeat (5) @(posedge clk); #1;

    // Glitch shorter than half a bit
    rx_drv = 1'b0;
    repeat (3) @(posedge clk); #1;
    rx_drv = 1'b1;
    repeat (100) @(posedge clk); #1;
    check("glitch_no_byte", rx_ne, 0);

    // Framing error, then a valid byte after the line recovers
    send_rx(8'h81, 1'b0);
    repeat (20) @(posedge clk); #1;
    check("framing_no_byte", rx_ne, 0);
    check("framing_keeps_data", rx_data, last_rx);
    rx_drv = 1'b1;
    repeat (10) @(posedge clk); #1;
    rx_model_frame(8'h42);
    send_rx(8'h42, 1'b1);
    repeat (10) @(posedge clk); #1;

    // Overrun and load/pop in the same cycle
    auto_pop = 1'b0;
    rx_model_frame(8'h11);
    send_rx(8'h11, 1'b1);
    repeat (3) @(posedge clk); #1;
    rx_model_frame(8'h22);
    send_rx(8'h22, 1'b1);
    repeat (3) @(posedge clk); #1;
    check("overrun_data", rx_data, rx_exp[rx_exp.size()-1]);
    check("overrun_ne", rx_ne, (rx_exp.size() != 0));
    rx_model_frame(8'h33);
    fork
      send_rx(8'h33, 1'b1);
      begin
        repeat (2 + B / 2 + 9 * B) @(posedge clk);
        #1;
        rd_main = 1'b1;
        @(posedge clk); #1;
        rd_main = 1'b0;
        @(negedge clk);
        check("load_pop_data", rx_data, 8'h33);
        check("load_pop_ne", rx_ne, 1);
      end
    join
    auto_pop = 1'b1;
    repeat (10) @(posedge clk); #1;

    // Asynchronous reset during bit 4 of 0xF0
    tx_mon_en = 1'b0;
    tx_write(8'hF0, 1'b0);
    repeat (5 * B + 2) @(posedge clk);
    #1;
    check("pre_reset_busy", tx_busy, 1);
    #3;
    rst = 1'b1;
    #1;
    check("mid_reset_busy", tx_busy, 0);
    check("mid_reset_line", uart_tx, 1);
    check("mid_reset_rx_ne", rx_ne, 0);
    check("mid_reset_rx_data", rx_data, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk); #1;
    tx_mon_en = 1'b1;
    repeat (2) @(posedge clk); #1;
    tx_write_exact(8'hF0);

    repeat (20) @(posedge clk); #1;
    check("tx_queue_drained", tx_exp.size(), 0);
    check("rx_queue_drained", rx_exp.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
